// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared constants and types for the timer scheduler
//
// Purpose: timer register map, timer control words and the scheduler FSM
// state encoding, shared by every file of the timer_scheduler slice.
// Ports: none (package).

package timer_sched_pkg;

   // Timer register map (byte addresses)
   localparam logic [31:0] TMR_ADDR_CONTROL   = 32'h0000_0000;
   localparam logic [31:0] TMR_ADDR_COMPARE   = 32'h0000_0008;
   localparam logic [31:0] TMR_ADDR_PRESCALER = 32'h0000_000C;

   // Timer CONTROL register words
   localparam logic [31:0] CTRL_REINIT = 32'h0000_0008;  // reinit counter, counting disabled
   localparam logic [31:0] CTRL_START  = 32'h0000_0003;  // count enable + interrupt enable
   localparam logic [31:0] CTRL_STOP   = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REINIT = 3'd1,
      WR_PSC = 3'd2,
      WR_CMP = 3'd3,
      START  = 3'd4,
      WAIT   = 3'd5,
      STOP   = 3'd6,
      DONE   = 3'd7
   } sched_state_t;

endpackage : timer_sched_pkg

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first set request at or after index ptr, wrapping
// around. The rotation pointer is owned and updated by the caller.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PW       index where the search starts
//   grant out NUM_REQ  one-hot winner (all zero when no request)
//   valid out 1        at least one request is set

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);

   logic [PW-1:0] idx;

   // Walk NUM_REQ positions starting at ptr with a wrapping index, so no
   // modulo is needed for non-power-of-two NUM_REQ.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
         idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
      end
   end

endmodule : rr_arbiter

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin sharing of one timer among requesters
//
// Purpose: grants the timer to one requester at a time, programs it
// (reinit, prescaler, compare, start), waits for its interrupt, stops it
// and pulses done to the owner. A zero compare value completes at once
// without touching the timer.
// Optional feature macro: TIMER_SCHED_WATCHDOG_EN adds a WAIT watchdog of
// WDT_CYCLES cycles that aborts with done+err.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req          in  NUM_REQ request levels, held until done
//   req_prescale in  NUM_REQ*32 per-requester prescaler value
//   req_compare  in  NUM_REQ*32 per-requester compare value
//   gnt          out NUM_REQ one-hot owner
//   done         out NUM_REQ one-cycle completion pulse
//   err          out NUM_REQ one-cycle watchdog abort pulse
//   busy         out 1       not in IDLE
//   tmr_address, tmr_wr_en, tmr_wr_data  timer register write port
//   tmr_interrupt in 1       timer expiry

module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter int          NUM_REQ    = 4,
   parameter logic [31:0] WDT_CYCLES = 32'd1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_prescale,
   input  logic [NUM_REQ*32-1:0] req_compare,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic [NUM_REQ-1:0]    err,
   output logic                  busy,
   output logic [31:0]           tmr_address,
   output logic                  tmr_wr_en,
   output logic [31:0]           tmr_wr_data,
   input  logic                  tmr_interrupt
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t              state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [PW-1:0]             owner_q, owner_d;
   logic [NUM_REQ-1:0]        gnt_q, gnt_d;
   logic [31:0]               psc_q, psc_d;
   logic [31:0]               cmp_q, cmp_d;

   logic [NUM_REQ-1:0]        arb_grant;
   logic                      arb_valid;
   logic [PW-1:0]             arb_idx;
   logic [PW-1:0]             scan_idx;
   logic [NUM_REQ-1:0][31:0]  psc_arr;
   logic [NUM_REQ-1:0][31:0]  cmp_arr;

`ifdef TIMER_SCHED_WATCHDOG_EN
   logic [31:0]               wdt_q, wdt_d;
   logic                      wdt_err_q, wdt_err_d;
`else
   logic                      unused_wdt_cycles;
   assign unused_wdt_cycles = ^WDT_CYCLES;
`endif

   assign psc_arr = req_prescale;
   assign cmp_arr = req_compare;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // One-hot grant to index
   always_comb begin
      arb_idx  = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[scan_idx]) arb_idx = scan_idx;
         scan_idx = scan_idx + PW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      psc_d   = psc_q;
      cmp_d   = cmp_q;
`ifdef TIMER_SCHED_WATCHDOG_EN
      wdt_d     = wdt_q;
      wdt_err_d = wdt_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_grant;
               owner_d = arb_idx;
               psc_d   = psc_arr[arb_idx];
               cmp_d   = cmp_arr[arb_idx];
               // A zero delay needs no timer at all
               state_d = (cmp_arr[arb_idx] == 32'd0) ? DONE : REINIT;
`ifdef TIMER_SCHED_WATCHDOG_EN
               wdt_err_d = 1'b0;
`endif
            end
         end
         REINIT: state_d = WR_PSC;
         WR_PSC: state_d = WR_CMP;
         WR_CMP: state_d = START;
         START: begin
            state_d = WAIT;
`ifdef TIMER_SCHED_WATCHDOG_EN
            wdt_d = 32'd0;
`endif
         end
         WAIT: begin
            if (tmr_interrupt) begin
               state_d = STOP;
            end
`ifdef TIMER_SCHED_WATCHDOG_EN
            // wdt_q counts completed WAIT cycles; this is the last allowed one
            else if (wdt_q == WDT_CYCLES - 32'd1) begin
               state_d   = STOP;
               wdt_err_d = 1'b1;
            end else begin
               wdt_d = wdt_q + 32'd1;
            end
`endif
         end
         STOP: state_d = DONE;
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         psc_q   <= '0;
         cmp_q   <= '0;
`ifdef TIMER_SCHED_WATCHDOG_EN
         wdt_q     <= '0;
         wdt_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         psc_q   <= psc_d;
         cmp_q   <= cmp_d;
`ifdef TIMER_SCHED_WATCHDOG_EN
         wdt_q     <= wdt_d;
         wdt_err_q <= wdt_err_d;
`endif
      end
   end

   // Timer bus decoded from registers only; no input reaches these outputs
   always_comb begin
      tmr_wr_en   = 1'b0;
      tmr_address = 32'd0;
      tmr_wr_data = 32'd0;
      case (state_q)
         REINIT: begin
            tmr_wr_en = 1'b1; tmr_address = TMR_ADDR_CONTROL;   tmr_wr_data = CTRL_REINIT;
         end
         WR_PSC: begin
            tmr_wr_en = 1'b1; tmr_address = TMR_ADDR_PRESCALER; tmr_wr_data = psc_q;
         end
         WR_CMP: begin
            tmr_wr_en = 1'b1; tmr_address = TMR_ADDR_COMPARE;   tmr_wr_data = cmp_q;
         end
         START: begin
            tmr_wr_en = 1'b1; tmr_address = TMR_ADDR_CONTROL;   tmr_wr_data = CTRL_START;
         end
         STOP: begin
            tmr_wr_en = 1'b1; tmr_address = TMR_ADDR_CONTROL;   tmr_wr_data = CTRL_STOP;
         end
         default: ;
      endcase
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE) ? gnt_q : '0;
`ifdef TIMER_SCHED_WATCHDOG_EN
   assign err  = (state_q == DONE && wdt_err_q) ? gnt_q : '0;
`else
   assign err  = '0;
`endif

endmodule : timer_scheduler

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed self-checking bench for timer_scheduler

module tb_timer_scheduler;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req = '0;
   logic [127:0] req_prescale = '0;
   logic [127:0] req_compare = '0;
   logic [3:0]   gnt, done, err;
   logic         busy;
   logic [31:0]  tmr_address, tmr_wr_data;
   logic         tmr_wr_en;
   logic         tmr_interrupt = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   timer_scheduler #(
      .NUM_REQ    (4),
      .WDT_CYCLES (32'd16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_prescale  (req_prescale),
      .req_compare   (req_compare),
      .gnt           (gnt),
      .done          (done),
      .err           (err),
      .busy          (busy),
      .tmr_address   (tmr_address),
      .tmr_wr_en     (tmr_wr_en),
      .tmr_wr_data   (tmr_wr_data),
      .tmr_interrupt (tmr_interrupt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge and compare every output for that cycle
   task automatic step(input string tag, input logic [3:0] g, input logic we,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] dn, input logic [3:0] er);
      @(negedge clk);
      check_eq({tag, " gnt"},  32'(gnt), 32'(g));
      check_eq({tag, " busy"}, 32'(busy), 32'(g != 4'd0));
      check_eq({tag, " wr_en"}, 32'(tmr_wr_en), 32'(we));
      check_eq({tag, " addr"}, tmr_address, a);
      check_eq({tag, " data"}, tmr_wr_data, d);
      check_eq({tag, " done"}, 32'(done), 32'(dn));
      check_eq({tag, " err"},  32'(err), 32'(er));
   endtask

   task automatic all_zero(input string tag);
      check_eq({tag, " gnt"},  32'(gnt), 0);
      check_eq({tag, " done"}, 32'(done), 0);
      check_eq({tag, " err"},  32'(err), 0);
      check_eq({tag, " busy"}, 32'(busy), 0);
      check_eq({tag, " wr_en"}, 32'(tmr_wr_en), 0);
      check_eq({tag, " addr"}, tmr_address, 0);
      check_eq({tag, " data"}, tmr_wr_data, 0);
   endtask

   // Four programming writes, starting the cycle after acceptance
   task automatic prog_steps(input string tag, input logic [3:0] oh,
                             input logic [31:0] psc, input logic [31:0] cmp);
      step({tag, " reinit"}, oh, 1'b1, 32'h0, 32'h08, 4'd0, 4'd0);
      step({tag, " psc"},    oh, 1'b1, 32'hC, psc,    4'd0, 4'd0);
      step({tag, " cmp"},    oh, 1'b1, 32'h8, cmp,    4'd0, 4'd0);
      step({tag, " start"},  oh, 1'b1, 32'h0, 32'h03, 4'd0, 4'd0);
   endtask

   // Full grant: program, wait n_wait cycles, interrupt, stop, done
   task automatic do_grant(input string tag, input logic [3:0] oh,
                           input logic [31:0] psc, input logic [31:0] cmp,
                           input int n_wait);
      prog_steps(tag, oh, psc, cmp);
      for (int i = 0; i < n_wait; i++)
         step({tag, " wait"}, oh, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0);
      tmr_interrupt = 1'b1;
      step({tag, " stop"}, oh, 1'b1, 32'h0, 32'h0, 4'd0, 4'd0);
      tmr_interrupt = 1'b0;
      step({tag, " done"}, oh, 1'b0, 32'h0, 32'h0, oh, 4'd0);
   endtask

   localparam logic [31:0] Z = 32'h0;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      all_zero("reset");
      rst = 1'b0;

      // Single request on index 2, prescale 0, compare 5, interrupt after 6 waits
      req_prescale[2*32 +: 32] = 32'd0;
      req_compare[2*32 +: 32]  = 32'd5;
      req = 4'b0100;
      do_grant("t1", 4'b0100, 32'd0, 32'd5, 6);
      req = 4'b0000;
      step("t1 idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      // Requesters 0 and 1 held from reset: alternate 0,1,0,1
      @(negedge clk);
      rst = 1'b1;
      req_prescale[0*32 +: 32] = 32'd7;
      req_compare[0*32 +: 32]  = 32'd1;
      req_prescale[1*32 +: 32] = 32'd9;
      req_compare[1*32 +: 32]  = 32'd2;
      req = 4'b0011;
      @(negedge clk);
      rst = 1'b0;
      do_grant("rr0a", 4'b0001, 32'd7, 32'd1, 1);
      step("rr gap1", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);
      do_grant("rr1a", 4'b0010, 32'd9, 32'd2, 1);
      step("rr gap2", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);
      do_grant("rr0b", 4'b0001, 32'd7, 32'd1, 2);
      step("rr gap3", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);
      do_grant("rr1b", 4'b0010, 32'd9, 32'd2, 1);
      req = 4'b0000;
      step("rr idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      // Compare 0 on index 3: done the cycle after acceptance, no writes
      req_prescale[3*32 +: 32] = 32'd4;
      req_compare[3*32 +: 32]  = 32'd0;
      req = 4'b1000;
      step("zero done", 4'b1000, 1'b0, Z, Z, 4'b1000, 4'd0);
      req = 4'b0000;
      step("zero idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      // Reset during WAIT, then a fresh sequence for index 1
      req_prescale[1*32 +: 32] = 32'd3;
      req_compare[1*32 +: 32]  = 32'd10;
      req = 4'b0010;
      prog_steps("rstw", 4'b0010, 32'd3, 32'd10);
      step("rstw wait", 4'b0010, 1'b0, Z, Z, 4'd0, 4'd0);
      rst = 1'b1;
      req = 4'b0000;
      #1;
      all_zero("rstw async");
      @(negedge clk);
      all_zero("rstw held");
      rst = 1'b0;
      req = 4'b0010;
      do_grant("rstw again", 4'b0010, 32'd3, 32'd10, 2);
      req = 4'b0000;
      step("rstw idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      // Stale interrupt in IDLE is ignored until WAIT
      tmr_interrupt = 1'b1;
      repeat (3) step("stale idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);
      req = 4'b0001;
      prog_steps("stale", 4'b0001, 32'd7, 32'd1);
      step("stale wait", 4'b0001, 1'b0, Z, Z, 4'd0, 4'd0);
      step("stale stop", 4'b0001, 1'b1, Z, Z, 4'd0, 4'd0);
      tmr_interrupt = 1'b0;
      req = 4'b0000;
      step("stale done", 4'b0001, 1'b0, Z, Z, 4'b0001, 4'd0);
      step("stale idle2", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      // Long wait without interrupt on index 2
      req = 4'b0100;
      prog_steps("wdt", 4'b0100, 32'd0, 32'd5);
`ifdef TIMER_SCHED_WATCHDOG_EN
      for (int i = 0; i < 16; i++)
         step("wdt wait", 4'b0100, 1'b0, Z, Z, 4'd0, 4'd0);
      step("wdt stop", 4'b0100, 1'b1, Z, Z, 4'd0, 4'd0);
      req = 4'b0000;
      step("wdt done", 4'b0100, 1'b0, Z, Z, 4'b0100, 4'b0100);
`else
      for (int i = 0; i < 20; i++)
         step("nowdt wait", 4'b0100, 1'b0, Z, Z, 4'd0, 4'd0);
      tmr_interrupt = 1'b1;
      step("nowdt stop", 4'b0100, 1'b1, Z, Z, 4'd0, 4'd0);
      tmr_interrupt = 1'b0;
      req = 4'b0000;
      step("nowdt done", 4'b0100, 1'b0, Z, Z, 4'b0100, 4'd0);
`endif
      step("final idle", 4'd0, 1'b0, Z, Z, 4'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_timer_scheduler
